decode_instr_window: RTL and testbench
======================================

Name: decode_instr_window

Overview:
- Byte-stream sequencer in front of the operand/opcode decode path.
- Accepts 32-bit little-endian fetch words into a circular byte buffer and presents an 88-bit (11-byte) `unescaped_instr` window aligned to the current instruction start.
- Advances the window by the instruction length reported by decode (prefix + opcode + ModR/M + SIB + `imm_disp_len`).
- Handles end-of-stream drain, flush, and illegal-length errors.

Parameters:
- FETCH_BYTES, 4: bytes per fetch word. Fixed at 4; `fetch_data` width is 8*FETCH_BYTES.
- BUF_BYTES, 16: circular buffer depth in bytes. Must be a power of two and ≥ WINDOW_BYTES + FETCH_BYTES.
- WINDOW_BYTES, 11: bytes presented to decode. Gives an 88-bit window.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- fetch_valid  in  1  fetch word offered
- fetch_ready  out  1  buffer can take a full fetch word this cycle
- fetch_data  in  32  byte0 = [7:0] is the lowest address
- fetch_last  in  1  qualifies the accepted word as the final word of the stream
- flush  in  1  discard all buffered bytes and end-of-stream state
- window_valid  out  1  window holds a decodable instruction start
- window  out  88  byte i at [8i+7:8i] = buffer[rd_ptr+i]; bytes at or beyond count read as 0
- consume_valid  in  1  decode reports instruction length
- consume_len  in  4  instruction length in bytes, legal range 1..WINDOW_BYTES
- count  out  5  buffered byte count, 0..16
- done  out  1  stream fully consumed
- err  out  1  sticky illegal-consume flag

Behaviour:
- Reset (rst_n=0 at posedge): rd_ptr=0, wr_ptr=0, count=0, eos=0, err=0, state=FILL.
  - Output values after reset: fetch_ready=1, window_valid=0, window=0, done=0.
- fetch_ready = (count ≤ BUF_BYTES−FETCH_BYTES) && state∉{DRAIN,DONE,ERR}.
  - Computed from registered count only; there is no same-cycle bypass of a consume.
- Fetch accept: fetch_valid && fetch_ready.
  - Writes 4 bytes at wr_ptr..wr_ptr+3 mod 16; wr_ptr += 4.
  - If fetch_last, eos=1.
- Latency: an accepted byte is visible in `window` the cycle after acceptance.
- window_valid:
  - state==RUN: 1 when count ≥ WINDOW_BYTES.
  - state==DRAIN: 1 when count > 0.
  - Otherwise 0.
- Consume: window_valid && consume_valid.
  - Legal when 1 ≤ consume_len ≤ min(count, WINDOW_BYTES): rd_ptr += consume_len mod 16.
  - Otherwise: err=1, state=ERR, no pointer change.
  - consume_valid while window_valid=0 is ignored; it is not an error.
- Simultaneous fetch and consume in one cycle: count' = count + 4 − consume_len. Pointers wrap independently mod 16.
- Count never exceeds 16; guaranteed by the fetch_ready rule.
- FSM transitions, evaluated on next-state values:
  - FILL: → RUN when count' ≥ 11; → DRAIN when eos'.
  - RUN: → DRAIN when eos'; → FILL when count' < 11 && !eos'.
  - DRAIN: → DONE when count' == 0.
  - DONE: holds. done=1, fetch_ready=0, window_valid=0.
  - ERR: holds. window_valid=0, fetch_ready=0. Exit only by flush or reset.
- flush (highest priority below reset):
  - Same-cycle fetch and consume are dropped.
  - Pointers, count and eos return to 0; state=FILL; err cleared.
- Reset asserted mid-operation discards everything; there is no partial-write retention.

Optional Feature:
- Macro: DECODE_INSTR_WINDOW_STATS_EN.
- When defined:
  - Adds output `instr_count` [31:0], incremented by 1 on every legal consume.
  - Adds output `stall_cycles` [31:0], incremented each cycle state==FILL && !eos.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset or flush.
- When undefined: the ports are absent and no counter logic is synthesized.

Test Plan:
- Reset, then words 32'h03020100, 32'h07060504, 32'h0B0A0908 on 3 consecutive cycles:
  - window_valid=1 on the 4th cycle.
  - window[87:0]=88'h0A09080706050403020100.
  - count=12.
- Steady state at count=12: consume_len=3 with a simultaneous fetch of 32'h0F0E0D0C:
  - next cycle count=13, window byte0=8'h03.
  - rd_ptr=3, wr_ptr=0 (wrapped).
- Last word 32'h13121110 with fetch_last=1 after 16 bytes consumed to count=4, then consume_len 2, 2:
  - DRAIN with window=88'h...0013121110 (high bytes zero).
  - done=1 after the second consume; fetch_ready=0.
- consume_len=0 and, separately, consume_len=12 at count=16:
  - err=1 next cycle, window_valid=0, pointers unchanged.
  - flush returns the block to FILL with err=0, count=0.
- Buffer full: count=13, fetch_valid held high:
  - fetch_ready=0 until consume_len=1 brings count to 12.
  - Word accepted the following cycle; no byte lost or duplicated across wrap.
- Flush asserted in the same cycle as a fetch and a consume:
  - count=0, window_valid=0 next cycle.
  - Fetched data is not written (confirmed by refilling with known bytes).

Source files
------------

// File: rtl/decode_instr_window.sv
// decode_instr_window
//   Byte-stream sequencer feeding the opcode/operand decoder. 32-bit
//   little-endian fetch words enter a 16-byte circular buffer. An 11-byte
//   window aligned to the current instruction start is presented to decode,
//   and decode retires each instruction by reporting its length.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   fetch_valid/ready   fetch word handshake; fetch_data byte0 = [7:0]
//   fetch_last          accepted word is the last word of the stream
//   flush               drop all buffered bytes and end-of-stream state
//   window_valid/window 88-bit window; bytes at or beyond count read as 0
//   consume_valid/len   instruction length reported by decode (1..11)
//   count               buffered byte count (0..16)
//   done                stream fully consumed
//   err                 sticky illegal-consume flag (cleared by flush/reset)
//
// Optional feature (macro DECODE_INSTR_WINDOW_STATS_EN)
//   instr_count   legal consumes, saturating
//   stall_cycles  cycles spent in FILL before end-of-stream, saturating
module decode_instr_window #(
  parameter int FETCH_BYTES  = 4,
  parameter int BUF_BYTES    = 16,
  parameter int WINDOW_BYTES = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic [8*FETCH_BYTES-1:0]      fetch_data,
  input  logic                          fetch_last,
  input  logic                          flush,
  output logic                          window_valid,
  output logic [8*WINDOW_BYTES-1:0]     window,
  input  logic                          consume_valid,
  input  logic [3:0]                    consume_len,
  output logic [$clog2(BUF_BYTES):0]    count,
  output logic                          done,
  output logic                          err
`ifdef DECODE_INSTR_WINDOW_STATS_EN
  ,
  output logic [31:0]                   instr_count,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int PTR_W = $clog2(BUF_BYTES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WINDOW_BYTES);
  localparam logic [CNT_W-1:0] FETCH_CNT = CNT_W'(FETCH_BYTES);
  localparam logic [CNT_W-1:0] FR_MAX    = CNT_W'(BUF_BYTES - FETCH_BYTES);

  typedef enum logic [2:0] {S_FILL, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

  logic [7:0]       r_buf [BUF_BYTES];
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_eos, r_err;
  state_t           r_state;

  logic             w_fetch_acc, w_cons_req, w_cons_legal, w_cons_bad;
  logic [CNT_W-1:0] w_len, w_count_next;
  logic             w_eos_next;
  logic [PTR_W-1:0] w_rd_next, w_wr_next;
  state_t           w_state_next;

  assign fetch_ready = (r_count <= FR_MAX) && (r_state == S_FILL || r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign err         = r_err;
  assign count       = r_count;

  always_comb begin
    window_valid = 1'b0;
    case (r_state)
      S_RUN:   window_valid = (r_count >= WIN_CNT);
      S_DRAIN: window_valid = (r_count != '0);
      default: window_valid = 1'b0;
    endcase
  end

  // Bytes past the valid count are masked so stale buffer contents never leak.
  always_comb begin
    window = '0;
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      if (CNT_W'(i) < r_count)
        window[8*i +: 8] = r_buf[PTR_W'(r_rd_ptr + PTR_W'(i))];
    end
  end

  assign w_fetch_acc  = fetch_valid && fetch_ready;
  assign w_cons_req   = window_valid && consume_valid;
  assign w_len        = CNT_W'(consume_len);
  assign w_cons_legal = w_cons_req && (w_len != '0) && (w_len <= r_count) && (w_len <= WIN_CNT);
  assign w_cons_bad   = w_cons_req && !w_cons_legal;

  assign w_count_next = r_count + (w_fetch_acc ? FETCH_CNT : '0) - (w_cons_legal ? w_len : '0);
  assign w_eos_next   = r_eos || (w_fetch_acc && fetch_last);
  assign w_rd_next    = r_rd_ptr + (w_cons_legal ? PTR_W'(consume_len) : '0);
  assign w_wr_next    = r_wr_ptr + (w_fetch_acc ? PTR_W'(FETCH_BYTES) : '0);

  // Transitions look at the post-update count and end-of-stream flag; an
  // end-of-stream takes precedence over the fill/run decision.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL: begin
        if (w_eos_next)                 w_state_next = S_DRAIN;
        else if (w_count_next >= WIN_CNT) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_eos_next)                 w_state_next = S_DRAIN;
        else if (w_count_next < WIN_CNT) w_state_next = S_FILL;
      end
      S_DRAIN: begin
        if (w_count_next == '0)         w_state_next = S_DONE;
      end
      default: w_state_next = r_state;
    endcase
    if (w_cons_bad) w_state_next = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_eos    <= 1'b0;
      r_err    <= 1'b0;
      r_state  <= S_FILL;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_eos    <= 1'b0;
      r_err    <= 1'b0;
      r_state  <= S_FILL;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= w_wr_next;
      r_count  <= w_count_next;
      r_eos    <= w_eos_next;
      r_state  <= w_state_next;
      if (w_cons_bad) r_err <= 1'b1;
    end
  end

  // Buffer storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && w_fetch_acc) begin
      for (int b = 0; b < FETCH_BYTES; b++)
        r_buf[PTR_W'(r_wr_ptr + PTR_W'(b))] <= fetch_data[8*b +: 8];
    end
  end

`ifdef DECODE_INSTR_WINDOW_STATS_EN
  logic [31:0] r_instr_count, r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_instr_count  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_cons_legal && r_instr_count != 32'hFFFF_FFFF)
        r_instr_count <= r_instr_count + 32'd1;
      if (r_state == S_FILL && !r_eos && r_stall_cycles != 32'hFFFF_FFFF)
        r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign instr_count  = r_instr_count;
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_decode_instr_window.sv
module tb_decode_instr_window;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, fetch_valid, fetch_last, flush, consume_valid;
  logic [31:0] fetch_data;
  logic [3:0]  consume_len;
  logic        fetch_ready, window_valid, done, err;
  logic [87:0] window;
  logic [4:0]  count;
`ifdef DECODE_INSTR_WINDOW_STATS_EN
  logic [31:0] instr_count, stall_cycles;
`endif

  decode_instr_window dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_last(fetch_last), .flush(flush),
    .window_valid(window_valid), .window(window),
    .consume_valid(consume_valid), .consume_len(consume_len),
    .count(count), .done(done), .err(err)
`ifdef DECODE_INSTR_WINDOW_STATS_EN
    , .instr_count(instr_count), .stall_cycles(stall_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: bytes held as a plain FIFO queue, no pointers.
  typedef enum {M_FILL, M_RUN, M_DRAIN, M_DONE, M_ERR} mode_e;
  byte unsigned q[$];
  bit      m_eos, m_err;
  mode_e   m_mode;
  longint  m_instr, m_stall;

  function automatic bit m_fetch_ready();
    return (q.size() <= 12) && (m_mode == M_FILL || m_mode == M_RUN);
  endfunction

  function automatic bit m_window_valid();
    if (m_mode == M_RUN)   return q.size() >= 11;
    if (m_mode == M_DRAIN) return q.size() > 0;
    return 1'b0;
  endfunction

  function automatic logic [87:0] m_window();
    logic [87:0] w = '0;
    for (int i = 0; i < 11; i++)
      if (i < q.size()) w[8*i +: 8] = q[i];
    return w;
  endfunction

  task automatic m_clear();
    q.delete();
    m_eos = 0; m_err = 0; m_mode = M_FILL; m_instr = 0; m_stall = 0;
  endtask

  task automatic model_step(input bit r, input bit fv, input logic [31:0] fd, input bit fl,
                            input bit fs, input bit cv, input logic [3:0] cl);
    bit fr, wv, acc, creq, legal, stall_now;
    int n;
    if (!r || fs) begin
      m_clear();
      return;
    end
    fr = m_fetch_ready();
    wv = m_window_valid();
    n  = q.size();
    stall_now = (m_mode == M_FILL) && !m_eos;
    acc   = fv && fr;
    creq  = wv && cv;
    legal = creq && (cl >= 1) && (int'(cl) <= n) && (cl <= 11);
    if (legal) repeat (int'(cl)) void'(q.pop_front());
    if (acc) begin
      for (int b = 0; b < 4; b++) q.push_back(fd[8*b +: 8]);
      if (fl) m_eos = 1;
    end
    if (creq && !legal) begin
      m_err  = 1;
      m_mode = M_ERR;
    end else begin
      case (m_mode)
        M_FILL:  if (m_eos) m_mode = M_DRAIN; else if (q.size() >= 11) m_mode = M_RUN;
        M_RUN:   if (m_eos) m_mode = M_DRAIN; else if (q.size() < 11) m_mode = M_FILL;
        M_DRAIN: if (q.size() == 0) m_mode = M_DONE;
        default: ;
      endcase
    end
    if (legal && m_instr < 64'hFFFF_FFFF) m_instr++;
    if (stall_now && m_stall < 64'hFFFF_FFFF) m_stall++;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("fetch_ready",  fetch_ready,  m_fetch_ready());
    chk("window_valid", window_valid, m_window_valid());
    chk("window",       window,       m_window());
    chk("count",        count,        q.size());
    chk("done",         done,         m_mode == M_DONE);
    chk("err",          err,          m_err);
`ifdef DECODE_INSTR_WINDOW_STATS_EN
    chk("instr_count",  instr_count,  m_instr[31:0]);
    chk("stall_cycles", stall_cycles, m_stall[31:0]);
`endif
  endtask

  // One clock: drive inputs, advance model, check every output after the edge.
  task automatic cycle(input bit r, input bit fv, input logic [31:0] fd, input bit fl,
                       input bit fs, input bit cv, input logic [3:0] cl);
    rst_n = r; fetch_valid = fv; fetch_data = fd; fetch_last = fl;
    flush = fs; consume_valid = cv; consume_len = cl;
    model_step(r, fv, fd, fl, fs, cv, cl);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic feed(input logic [31:0] w);
    cycle(1, 1, w, 0, 0, 0, 4'd0);
  endtask

  task automatic consume(input logic [3:0] l);
    cycle(1, 0, 32'h0, 0, 0, 1, l);
  endtask

  task automatic do_flush();
    cycle(1, 0, 32'h0, 0, 1, 0, 4'd0);
  endtask

  initial begin
    bit r, fv, fl, fs, cv;
    logic [31:0] fd;
    logic [3:0]  cl;
    int mx;

    rst_n = 0; fetch_valid = 0; fetch_data = '0; fetch_last = 0;
    flush = 0; consume_valid = 0; consume_len = '0;
    m_clear();
    @(posedge clk); #1;

    // Reset values
    cycle(0, 0, 32'h0, 0, 0, 0, 4'd0);
    cycle(0, 0, 32'h0, 0, 0, 0, 4'd0);
    chk("rst fetch_ready", fetch_ready, 1'b1);
    chk("rst window_valid", window_valid, 1'b0);
    chk("rst window", window, 88'h0);
    chk("rst done", done, 1'b0);

    // Initial fill
    feed(32'h03020100);
    feed(32'h07060504);
    feed(32'h0B0A0908);
    chk("fill window_valid", window_valid, 1'b1);
    chk("fill window", window, 88'h0A09080706050403020100);
    chk("fill count", count, 5'd12);

    // Consume 3 with simultaneous fetch; write pointer wraps
    cycle(1, 1, 32'h0F0E0D0C, 0, 0, 1, 4'd3);
    chk("sim count", count, 5'd13);
    chk("sim byte0", window[7:0], 8'h03);
    chk("sim window", window, 88'h0D0C0B0A09080706050403);
    chk("full fetch_ready", fetch_ready, 1'b0);

    // Full buffer: last word held, refused until a consume frees room
    cycle(1, 1, 32'h13121110, 1, 0, 1, 4'd1);
    chk("room count", count, 5'd12);
    chk("room fetch_ready", fetch_ready, 1'b1);
    cycle(1, 1, 32'h13121110, 1, 0, 0, 4'd0);
    chk("last count", count, 5'd16);
    chk("last fetch_ready", fetch_ready, 1'b0);
    chk("last window", window, 88'h0E0D0C0B0A090807060504);

    // Drain
    consume(4'd11);
    chk("drain5 window", window, 88'h000000000000131211100F);
    consume(4'd1);
    chk("drain4 window", window, 88'h0000000000000013121110);
    chk("drain4 valid", window_valid, 1'b1);
    consume(4'd2);
    chk("drain2 window", window, 88'h1312);
    consume(4'd2);
    chk("done", done, 1'b1);
    chk("done fetch_ready", fetch_ready, 1'b0);
    chk("done window_valid", window_valid, 1'b0);

    // Oversized consume at count 16
    do_flush();
    feed(32'h03020100); feed(32'h07060504); feed(32'h0B0A0908); feed(32'h0F0E0D0C);
    chk("pre-err count", count, 5'd16);
    consume(4'd12);
    chk("err12 err", err, 1'b1);
    chk("err12 window_valid", window_valid, 1'b0);
    chk("err12 count", count, 5'd16);
    chk("err12 window", window, 88'h0A09080706050403020100);
    do_flush();
    chk("flush err", err, 1'b0);
    chk("flush count", count, 5'd0);
    chk("flush fetch_ready", fetch_ready, 1'b1);

    // Zero-length consume
    feed(32'h03020100); feed(32'h07060504); feed(32'h0B0A0908);
    consume(4'd0);
    chk("err0 err", err, 1'b1);
    chk("err0 count", count, 5'd12);
    do_flush();

    // Flush together with fetch and consume
    feed(32'h03020100); feed(32'h07060504); feed(32'h0B0A0908);
    cycle(1, 1, 32'hDEADBEEF, 0, 1, 1, 4'd3);
    chk("fl count", count, 5'd0);
    chk("fl window_valid", window_valid, 1'b0);
    feed(32'h44434241); feed(32'h48474645); feed(32'h4C4B4A49);
    chk("refill window", window, 88'h4B4A494847464544434241);
    chk("refill count", count, 5'd12);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(0, 299) != 0);
      fs = ($urandom_range(0, 79) == 0) ||
           ((m_mode == M_DONE || m_mode == M_ERR) && $urandom_range(0, 3) == 0);
      fv = ($urandom_range(0, 2) != 0);
      fd = $urandom;
      fl = ($urandom_range(0, 59) == 0);
      cv = $urandom_range(0, 1);
      mx = (q.size() < 11) ? q.size() : 11;
      if ($urandom_range(0, 49) == 0) begin
        cl = $urandom_range(0, 1) ? 4'd0 : 4'(mx + 1);
        fv = 0;
      end else begin
        cl = (mx > 0) ? 4'($urandom_range(1, mx)) : 4'($urandom_range(0, 15));
      end
      cycle(r, fv, fd, fl, fs, cv, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
